// File: rtl/cosine_sim_pkg.sv
// rtl/cosine_sim_pkg.sv - shared types and constants for the cosine-similarity job controller
//
// Contents:
//   ctrl_state_t  controller FSM state encoding
//   DW_DEFAULT    default element / result width
//   JOBCNT_W      width of the completed-job counter
package cosine_sim_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } ctrl_state_t;

    localparam int DW_DEFAULT = 32;
    localparam int JOBCNT_W   = 16;

endpackage

// File: rtl/cosine_sim_ctrl.sv
// rtl/cosine_sim_ctrl.sv - job controller that assembles vectors for a cosine-similarity engine
//
// Collects W element pairs from a valid/ready stream into two vectors,
// launches the external engine with a one-cycle start pulse, waits for
// its result under a timeout, and presents the result (or an error) on a
// valid/ready response port.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s_valid/s_ready/s_last      element-pair input handshake, s_last ends a job
//   s_a, s_b                    element of vector A / vector B
//   eng_start                   one-cycle engine launch pulse
//   eng_vec_a, eng_vec_b        assembled vectors, stable while the engine runs
//   eng_similarity, eng_valid   engine result and its single-cycle strobe
//   m_valid/m_ready             response handshake
//   m_similarity, m_error       captured result, error flag (length error or timeout)
//   busy                        high whenever not collecting a fresh job
//   job_count                   number of error-free jobs delivered (wraps)
module cosine_sim_ctrl
    import cosine_sim_pkg::*;
#(
    parameter int W       = 5,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DW-1:0]           s_a,
    input  logic [DW-1:0]           s_b,
    input  logic                    s_last,
    output logic                    eng_start,
    output logic [W-1:0][DW-1:0]    eng_vec_a,
    output logic [W-1:0][DW-1:0]    eng_vec_b,
    input  logic [DW-1:0]           eng_similarity,
    input  logic                    eng_valid,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DW-1:0]           m_similarity,
    output logic                    m_error,
    output logic                    busy,
    output logic [JOBCNT_W-1:0]     job_count
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    ctrl_state_t              state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [W-1:0][DW-1:0]     vec_a_q, vec_a_d;
    logic [W-1:0][DW-1:0]     vec_b_q, vec_b_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [DW-1:0]            sim_q, sim_d;
    logic                     err_q, err_d;
    logic [JOBCNT_W-1:0]      jcnt_q, jcnt_d;

    logic xfer;

    // s_ready is gated by rst directly: the state register already reads
    // LOAD during reset, which would otherwise advertise readiness.
    assign s_ready      = !rst && (state_q == ST_LOAD || state_q == ST_DRAIN);
    assign xfer         = s_valid && s_ready;
    assign eng_start    = (state_q == ST_START);
    assign m_valid      = (state_q == ST_RESP);
    assign busy         = (state_q != ST_LOAD);
    assign eng_vec_a    = vec_a_q;
    assign eng_vec_b    = vec_b_q;
    assign m_similarity = sim_q;
    assign m_error      = err_q;
    assign job_count    = jcnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_a_d = vec_a_q;
        vec_b_d = vec_b_q;
        tmo_d   = tmo_q;
        sim_d   = sim_q;
        err_d   = err_q;
        jcnt_d  = jcnt_q;

        unique case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    vec_a_d[idx_q] = s_a;
                    vec_b_d[idx_q] = s_b;
                    idx_d          = idx_q + IDX_W'(1);
                    if (s_last) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_START;
                        end else begin
                            // Job ended early: report a length error.
                            state_d = ST_RESP;
                            sim_d   = '0;
                            err_d   = 1'b1;
                        end
                    end else if (idx_q == IDX_LAST) begin
                        // Vectors full but job continues: swallow the excess.
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (xfer && s_last) begin
                    state_d = ST_RESP;
                    sim_d   = '0;
                    err_d   = 1'b1;
                end
            end

            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // eng_valid is checked first so a result arriving on the
                // final timeout cycle is still delivered.
                if (eng_valid) begin
                    sim_d   = eng_similarity;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    sim_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_RESP: begin
                if (m_ready) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    if (!err_q) begin
                        jcnt_d = jcnt_q + JOBCNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            vec_a_q <= '0;
            vec_b_q <= '0;
            tmo_q   <= '0;
            sim_q   <= '0;
            err_q   <= 1'b0;
            jcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_a_q <= vec_a_d;
            vec_b_q <= vec_b_d;
            tmo_q   <= tmo_d;
            sim_q   <= sim_d;
            err_q   <= err_d;
            jcnt_q  <= jcnt_d;
        end
    end

endmodule
